// File: rtl/key_sched_loader.sv
// key_sched_loader
//   AES-128 round-key expansion and broadcast engine. On an accepted start it
//   drives the raw cipher key and then one expanded round key per cycle onto
//   the shared rkey/addr load bus. Each downstream stage captures the key
//   whose addr matches its own index.
//
// Ports
//   clk      : single clock; all state changes on the rising edge
//   rst      : asynchronous, active-high reset
//   key_in   : 128-bit cipher key; byte 0 is key_in[127:120]
//   key_load : start request; taken only while busy is low
//   rkey     : round key on the load bus
//   addr     : target stage index; 0 means no write
//   busy     : high while a schedule is being broadcast
//   done     : one-cycle pulse after the last round key
module key_sched_loader #(
    parameter logic [3:0] FIRST_ADDR = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic [127:0] rkey,
    output logic [3:0]   addr,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BCAST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]   state;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    logic [31:0]  w0, w1, w2, w3, temp;
    logic [31:0]  n0, n1, n2, n3;
    logic         start;

    // SubWord(RotWord(w3)): the rotation is folded into the byte order here.
    always_comb begin
        w0   = rkey[127:96];
        w1   = rkey[95:64];
        w2   = rkey[63:32];
        w3   = rkey[31:0];
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon, 24'h0};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
    end

    // busy is low in IDLE and DONE, so a request in the done cycle chains
    // straight into the next schedule.
    assign start = key_load && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rnd   <= 4'd0;
            rcon  <= 8'h01;
            rkey  <= 128'h0;
            addr  <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_BCAST: begin
                    if (rnd == 4'd10) begin
                        state <= ST_DONE;
                        addr  <= 4'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rkey  <= {n0, n1, n2, n3};
                        rcon  <= xtime(rcon);
                        rnd   <= rnd + 4'd1;
                        addr  <= addr + 4'd1;
                    end
                end
                default: begin
                    // IDLE and DONE behave the same apart from clearing done.
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_BCAST;
                        rkey  <= key_in;
                        addr  <= FIRST_ADDR;
                        busy  <= 1'b1;
                        rcon  <= 8'h01;
                        rnd   <= 4'd0;
                    end else begin
                        state <= ST_IDLE;
                        addr  <= 4'd0;
                    end
                end
            endcase
        end
    end

endmodule
